uart_stream_ctrl: RTL
=====================

// Module: uart_stream_ctrl
// PURPOSE
// - Sequencer/arbiter in front of the UART register-file port. Shares the port between a host (CPU/AXI) requester and an
//   internal stream engine that moves bytes between valid/ready streams and the TX_DATA/RX_DATA registers by polling STATUS.
// - Host has priority; the stream engine is guaranteed one slot after HOST_BURST_MAX consecutive host grants.
// PARAMETERS
// - DATA_WIDTH      32  register data width
// - ADDR_WIDTH      4   word-index register address width
// - HOST_BURST_MAX  4   max consecutive host grants while the stream engine is requesting (>=1)
// - POLL_GAP        8   idle cycles between STATUS polls when no transfer is possible (>=1)
// - TIMEOUT_POLLS   255 consecutive polls blocked with tx_full before tx_timeout (UART_STREAM_TIMEOUT_EN only)
// PORTS
// - clk  in 1  clock
// - rst_n  in 1  asynchronous active-low reset
// - host_addr/host_wdata/host_wstrb  in  ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  host access
// - host_wen/host_ren  in 1  host write/read request (mutually exclusive)
// - host_ready  out 1  host access accepted this cycle
// - host_rdata/host_error  out DATA_WIDTH/1  reg_rdata/reg_error forwarded in the cycle host_ready=1, else 0
// - reg_addr/reg_wdata/reg_wstrb/reg_wen/reg_ren  out  to register file; reg_rdata/reg_error in (combinational, same cycle)
// - stream_en  in 1  enable stream engine
// - tx_data/tx_valid in 8/1, tx_ready out 1  byte stream into TX_DATA
// - rx_data/rx_valid out 8/1, rx_ready in 1  byte stream out of RX_DATA
// - tx_timeout  out 1  sticky TX-blocked flag (0 when macro absent)
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; counters, burst count and TX/RX toggle cleared; rx_valid=0. Async reset mid-access aborts it.
// - One register access per cycle; reg_* driven combinationally from winner; at most one of reg_wen/reg_ren high.
// - Arbitration: stream wins if it requests and burst_cnt==HOST_BURST_MAX, or host idle; else host wins. burst_cnt
//   increments per host grant while stream requests, clears on stream grant or stream not requesting; saturates.
// - Stream stalled by host stays in its state and re-requests; no state advances without a grant.
// - FSM: IDLE -(stream_en rise)-> INIT: write CTRL=0x3, wstrb=0x1 -> POLL: read STATUS, capture bit1 tx_full, bit2 rx_empty.
//   POLL decision: can_tx=tx_valid&!tx_full; can_rx=!rx_empty&!rx_valid. Both -> choose per toggle (starts TX), toggle flips.
//   can_tx -> TXW: write TX_DATA=tx_data, tx_ready=1 for that granted cycle only, -> POLL.
//   can_rx -> RXR: read RX_DATA, load rx_data=reg_rdata[7:0], rx_valid=1 next cycle, -> POLL.
//   neither -> WAIT: count POLL_GAP cycles -> POLL.
// - rx_valid holds until rx_valid&rx_ready; RXR never issued while rx_valid=1 (1-entry output buffer, no overwrite).
// - reg_error on a stream access: ignored for STATUS/TX, byte dropped on RXR (rx_valid stays 0); host sees reg_error.
// - stream_en low: finish current granted access, then IDLE; no CTRL write on disable; held rx byte remains offered.
// - stream_en re-rise re-runs INIT. Host writes to CTRL are not shadowed; host may disable TX/RX underneath stream engine.
// - Counters: POLL_GAP counter $clog2(POLL_GAP+1) bits, reload on WAIT entry, no wrap.
// CONFIGURATION
// - UART_STREAM_TIMEOUT_EN defined: blk_cnt counts POLLs with tx_valid&tx_full, clears on any TXW; at TIMEOUT_POLLS
//   tx_timeout=1 sticky until stream_en falls or reset; counter saturates.
// - Undefined: no counter, tx_timeout tied 0.
// STRUCTURE
// - uart_pkg: register word indices (CTRL=0,STATUS=1,TX_DATA=2,RX_DATA=3), STATUS bit positions, stream_state_e enum.
// - Sub-module uart_reg_arb: 2-way host-priority arbiter with burst limit and mux; FSM stays in uart_stream_ctrl.
// TESTING
// - stream_en=1, host idle -> CTRL write 0x3, then STATUS read at cycle 2; tx_valid 0xA5 with tx_full=0 -> TX_DATA write 0xA5, tx_ready 1 cycle.
// - Host reads every cycle, stream requesting, HOST_BURST_MAX=4 -> host_ready pattern 1,1,1,1,0 repeating; stream advances.
// - STATUS rx_empty=0, RX_DATA reads 0x3C, rx_ready=0 -> rx_valid=1 rx_data=0x3C held, no further RX_DATA reads until rx_ready.
// - tx_valid & rx both possible on consecutive polls -> TXW, RXR, TXW alternation.
// - tx_full=1 forever, TIMEOUT_POLLS=3, macro on -> tx_timeout rises after 3rd blocked poll; macro off -> stays 0.
// - rst_n low during TXW -> all outputs 0 next cycle, restart requires stream_en edge and INIT write.

Source files
------------

// File: rtl/uart_stream_ctrl_pkg.sv
// Shared register map, STATUS bit positions and stream engine state encoding
// for the UART stream controller slice.
package uart_stream_ctrl_pkg;

    localparam int unsigned REG_CTRL    = 32'd0;
    localparam int unsigned REG_STATUS  = 32'd1;
    localparam int unsigned REG_TX_DATA = 32'd2;
    localparam int unsigned REG_RX_DATA = 32'd3;

    localparam int unsigned STATUS_TX_FULL_BIT  = 32'd1;
    localparam int unsigned STATUS_RX_EMPTY_BIT = 32'd2;

    // CTRL value written on stream start: TX and RX enabled
    localparam int unsigned CTRL_ENABLE_VAL = 32'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_POLL = 3'd2,
        ST_TXW  = 3'd3,
        ST_RXR  = 3'd4,
        ST_WAIT = 3'd5
    } stream_state_e;

    // States that issue a register access and therefore request the port
    function automatic logic is_access_state(input stream_state_e st);
        logic res;
        case (st)
            ST_INIT, ST_POLL, ST_TXW, ST_RXR: res = 1'b1;
            default:                          res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_stream_ctrl_reg_arb.sv
// Two-way host-priority arbiter for the UART register port, with a burst
// limit that guarantees the stream engine a slot, plus the access mux.
module uart_stream_ctrl_reg_arb #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int HOST_BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   host_addr,
    input  logic [DATA_WIDTH-1:0]   host_wdata,
    input  logic [DATA_WIDTH/8-1:0] host_wstrb,
    input  logic                    host_wen,
    input  logic                    host_ren,
    output logic                    host_ready,
    output logic [DATA_WIDTH-1:0]   host_rdata,
    output logic                    host_error,
    input  logic                    stream_req,
    input  logic [ADDR_WIDTH-1:0]   stream_addr,
    input  logic [DATA_WIDTH-1:0]   stream_wdata,
    input  logic [DATA_WIDTH/8-1:0] stream_wstrb,
    input  logic                    stream_wen,
    output logic                    stream_gnt,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    output logic                    reg_wen,
    output logic                    reg_ren,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_error
);

    localparam int BURST_W = $clog2(HOST_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(HOST_BURST_MAX);

    logic               host_req_s;
    logic               host_gnt_s;
    logic [BURST_W-1:0] burst_cnt_r;

    assign host_req_s = host_wen | host_ren;

    // Grant decision: stream wins when host is idle or the host burst is used up
    always_comb begin
        stream_gnt = stream_req && ((burst_cnt_r == BURST_MAX) || !host_req_s);
        host_gnt_s = host_req_s && !stream_gnt;
    end

    // Register port mux; write takes precedence so wen/ren are never both high
    always_comb begin
        reg_addr  = '0;
        reg_wdata = '0;
        reg_wstrb = '0;
        reg_wen   = 1'b0;
        reg_ren   = 1'b0;
        if (stream_gnt) begin
            reg_addr  = stream_addr;
            reg_wdata = stream_wdata;
            reg_wstrb = stream_wstrb;
            reg_wen   = stream_wen;
            reg_ren   = !stream_wen;
        end else if (host_gnt_s) begin
            reg_addr  = host_addr;
            reg_wdata = host_wdata;
            reg_wstrb = host_wstrb;
            reg_wen   = host_wen;
            reg_ren   = host_ren && !host_wen;
        end else begin
            reg_addr  = '0;
        end
    end

    // Host response forwarding, zero when the host is not served
    always_comb begin
        host_ready = host_gnt_s;
        if (host_gnt_s) begin
            host_rdata = reg_rdata;
            host_error = reg_error;
        end else begin
            host_rdata = '0;
            host_error = 1'b0;
        end
    end

    // Consecutive host grants seen while the stream engine waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_r <= '0;
        end else if (stream_gnt || !stream_req) begin
            burst_cnt_r <= '0;
        end else if (host_gnt_s && (burst_cnt_r != BURST_MAX)) begin
            burst_cnt_r <= burst_cnt_r + BURST_W'(1'b1);
        end
    end

endmodule

// File: rtl/uart_stream_ctrl.sv
// UART register-port sequencer: host access plus a polling stream engine moving
// bytes between tx/rx streams and TX_DATA/RX_DATA. UART_STREAM_TIMEOUT_EN adds tx_timeout.
module uart_stream_ctrl
    import uart_stream_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int HOST_BURST_MAX = 4,
    parameter int POLL_GAP       = 8,
    parameter int TIMEOUT_POLLS  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   host_addr,
    input  logic [DATA_WIDTH-1:0]   host_wdata,
    input  logic [DATA_WIDTH/8-1:0] host_wstrb,
    input  logic                    host_wen,
    input  logic                    host_ren,
    output logic                    host_ready,
    output logic [DATA_WIDTH-1:0]   host_rdata,
    output logic                    host_error,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    output logic                    reg_wen,
    output logic                    reg_ren,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_error,
    input  logic                    stream_en,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    tx_timeout
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int GAP_W  = $clog2(POLL_GAP + 1);

    stream_state_e           state_r;
    logic                    stream_en_d_r;
    logic                    toggle_r;
    logic [GAP_W-1:0]        gap_cnt_r;
    logic                    stream_req_s;
    logic                    stream_gnt_s;
    logic                    stream_wen_s;
    logic [ADDR_WIDTH-1:0]   stream_addr_s;
    logic [DATA_WIDTH-1:0]   stream_wdata_s;
    logic [STRB_W-1:0]       stream_wstrb_s;
    logic                    tx_full_s;
    logic                    rx_empty_s;
    logic                    can_tx_s;
    logic                    can_rx_s;
    logic                    en_rise_s;

    assign en_rise_s  = stream_en & ~stream_en_d_r;
    assign tx_full_s  = reg_rdata[STATUS_TX_FULL_BIT];
    assign rx_empty_s = reg_rdata[STATUS_RX_EMPTY_BIT];
    // rx_valid blocks RX so the held byte is never overwritten
    assign can_tx_s   = tx_valid & ~tx_full_s;
    assign can_rx_s   = ~rx_empty_s & ~rx_valid;
    assign tx_ready   = stream_gnt_s && (state_r == ST_TXW);

    // Stream engine access request; gated by stream_en so a disable issues nothing new
    always_comb begin
        stream_req_s   = stream_en && is_access_state(state_r);
        stream_wen_s   = 1'b0;
        stream_addr_s  = '0;
        stream_wdata_s = '0;
        stream_wstrb_s = '0;
        case (state_r)
            ST_INIT: begin
                stream_wen_s   = 1'b1;
                stream_addr_s  = ADDR_WIDTH'(REG_CTRL);
                stream_wdata_s = DATA_WIDTH'(CTRL_ENABLE_VAL);
                stream_wstrb_s = STRB_W'(1'b1);
            end
            ST_POLL: stream_addr_s = ADDR_WIDTH'(REG_STATUS);
            ST_TXW: begin
                stream_wen_s   = 1'b1;
                stream_addr_s  = ADDR_WIDTH'(REG_TX_DATA);
                stream_wdata_s = DATA_WIDTH'(tx_data);
                stream_wstrb_s = STRB_W'(1'b1);
            end
            ST_RXR:  stream_addr_s = ADDR_WIDTH'(REG_RX_DATA);
            default: stream_addr_s = '0;
        endcase
    end

    uart_stream_ctrl_reg_arb #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .HOST_BURST_MAX (HOST_BURST_MAX)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_wstrb   (host_wstrb),
        .host_wen     (host_wen),
        .host_ren     (host_ren),
        .host_ready   (host_ready),
        .host_rdata   (host_rdata),
        .host_error   (host_error),
        .stream_req   (stream_req_s),
        .stream_addr  (stream_addr_s),
        .stream_wdata (stream_wdata_s),
        .stream_wstrb (stream_wstrb_s),
        .stream_wen   (stream_wen_s),
        .stream_gnt   (stream_gnt_s),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_wstrb    (reg_wstrb),
        .reg_wen      (reg_wen),
        .reg_ren      (reg_ren),
        .reg_rdata    (reg_rdata),
        .reg_error    (reg_error)
    );

    // Stream engine FSM; every state change except WAIT countdown needs a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            stream_en_d_r <= 1'b0;
            toggle_r      <= 1'b0;
            gap_cnt_r     <= '0;
            rx_valid      <= 1'b0;
            rx_data       <= 8'h00;
        end else begin
            stream_en_d_r <= stream_en;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (!stream_en) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: if (en_rise_s) state_r <= ST_INIT;
                    ST_INIT: if (stream_gnt_s) state_r <= ST_POLL;
                    ST_POLL: begin
                        if (stream_gnt_s) begin
                            if (can_tx_s && can_rx_s) begin
                                toggle_r <= ~toggle_r;
                                state_r  <= toggle_r ? ST_RXR : ST_TXW;
                            end else if (can_tx_s) begin
                                state_r <= ST_TXW;
                            end else if (can_rx_s) begin
                                state_r <= ST_RXR;
                            end else begin
                                state_r   <= ST_WAIT;
                                gap_cnt_r <= GAP_W'(POLL_GAP);
                            end
                        end
                    end
                    ST_TXW: if (stream_gnt_s) state_r <= ST_POLL;
                    ST_RXR: begin
                        if (stream_gnt_s) begin
                            state_r <= ST_POLL;
                            // an errored read drops the byte rather than offer garbage
                            if (!reg_error) begin
                                rx_data  <= reg_rdata[7:0];
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (gap_cnt_r > GAP_W'(1'b1)) begin
                            gap_cnt_r <= gap_cnt_r - GAP_W'(1'b1);
                        end else begin
                            state_r <= ST_POLL;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef UART_STREAM_TIMEOUT_EN
    localparam int BLK_W = $clog2(TIMEOUT_POLLS + 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(TIMEOUT_POLLS);

    logic [BLK_W-1:0] blk_cnt_r;
    logic             tx_timeout_r;
    logic             en_fall_s;

    assign en_fall_s  = ~stream_en & stream_en_d_r;
    assign tx_timeout = tx_timeout_r;

    // Blocked-poll counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_r    <= '0;
            tx_timeout_r <= 1'b0;
        end else if (en_fall_s) begin
            blk_cnt_r    <= '0;
            tx_timeout_r <= 1'b0;
        end else if (stream_gnt_s && (state_r == ST_TXW)) begin
            blk_cnt_r <= '0;
        end else if (stream_gnt_s && (state_r == ST_POLL) && tx_valid && tx_full_s) begin
            if (blk_cnt_r != BLK_MAX) begin
                blk_cnt_r <= blk_cnt_r + BLK_W'(1'b1);
            end
            if (blk_cnt_r >= (BLK_MAX - BLK_W'(1'b1))) begin
                tx_timeout_r <= 1'b1;
            end
        end
    end
`else
    localparam int timeout_polls_unused = TIMEOUT_POLLS;
    assign tx_timeout = 1'b0;
`endif

endmodule
